// File: rtl/loader_pkg.sv
// Shared state encoding and protocol constants for the instruction loader.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
      S_DONE,
      S_ERROR
`ifdef LOADER_CHECKSUM_EN
      , S_CHECK
`endif
   } state_t;

   localparam int MIN_COUNT      = 1;
   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_assembler.sv
// Packs received bytes into instruction words, most significant byte first.
// o_complete/o_word are combinational so the top can register the write on the 4th byte's edge.
module word_assembler
   import loader_pkg::*;
#(
   parameter int SIZE = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_clear,
   input  logic            i_valid,
   input  logic [7:0]      i_byte,
   output logic            o_complete,
   output logic [SIZE-1:0] o_word
);

   // Only the earlier bytes are stored; the final byte is taken straight from the input.
   logic [SIZE-9:0]       shift_q;
   logic [BYTE_IDX_W-1:0] idx;

   assign o_complete = i_valid && (int'(idx) == BYTES_PER_WORD - 1);
   assign o_word     = {shift_q, i_byte};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         idx     <= '0;
         shift_q <= '0;
      end else if (i_valid) begin
         shift_q <= {shift_q[SIZE-17:0], i_byte};
         idx     <= o_complete ? '0 : idx + BYTE_IDX_W'(1);
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// Loads N instruction words from the UART byte stream into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module instruction_loader
   import loader_pkg::*;
#(
   parameter int SIZE           = 32,
   parameter int MEM_SIZE       = 64,
   parameter int ADDR_WIDTH     = $clog2(MEM_SIZE),
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_done,
   output logic                  o_inst_write_enable,
   output logic [ADDR_WIDTH-1:0] o_write_addr,
   output logic [SIZE-1:0]       o_write_data,
   output logic                  o_loading,
   output logic                  o_done,
   output logic                  o_error,
   output state_t                o_state
);

   localparam int CNT_W = $clog2(MEM_SIZE + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   state_t           state;
   logic [CNT_W-1:0] word_cnt;
   logic [7:0]       n_words;
   logic [TO_W-1:0]  timeout_cnt;
   logic             busy;
   logic             start_ok;
   logic             asm_valid;
   logic             asm_complete;
   logic             timeout_hit;
   logic [SIZE-1:0]  asm_word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]       checksum;
`endif

   always_comb begin
      busy = 1'b0;
      case (state)
         S_COUNT, S_DATA: busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         S_CHECK:         busy = 1'b1;
`endif
         default:         busy = 1'b0;
      endcase
   end

   assign start_ok    = i_start && !busy;
   assign asm_valid   = i_rx_done && (state == S_DATA);
   assign timeout_hit = busy && !i_rx_done && (int'(timeout_cnt) + 1 >= TIMEOUT_CYCLES);
   assign o_state     = state;

   word_assembler #(.SIZE(SIZE)) u_asm (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clear    (start_ok),
      .i_valid    (asm_valid),
      .i_byte     (i_rx_data),
      .o_complete (asm_complete),
      .o_word     (asm_word)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state               <= S_IDLE;
         word_cnt            <= '0;
         n_words             <= '0;
         timeout_cnt         <= '0;
         o_inst_write_enable <= 1'b0;
         o_write_addr        <= '0;
         o_write_data        <= '0;
         o_loading           <= 1'b0;
         o_done              <= 1'b0;
         o_error             <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         checksum            <= '0;
`endif
      end else begin
         o_inst_write_enable <= 1'b0;
         if (busy) timeout_cnt <= i_rx_done ? '0 : timeout_cnt + TO_W'(1);
         if (timeout_hit) begin
            // A partially assembled word is simply dropped; earlier writes stay in memory.
            state     <= S_ERROR;
            o_error   <= 1'b1;
            o_loading <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE, S_ERROR: begin
                  if (i_start) begin
                     state       <= S_COUNT;
                     o_done      <= 1'b0;
                     o_error     <= 1'b0;
                     o_loading   <= 1'b1;
                     timeout_cnt <= '0;
                     word_cnt    <= '0;
`ifdef LOADER_CHECKSUM_EN
                     checksum    <= '0;
`endif
                  end
               end
               S_COUNT: begin
                  if (i_rx_done) begin
                     if (int'(i_rx_data) < MIN_COUNT || int'(i_rx_data) > MEM_SIZE) begin
                        state     <= S_ERROR;
                        o_error   <= 1'b1;
                        o_loading <= 1'b0;
                     end else begin
                        n_words  <= i_rx_data;
                        word_cnt <= '0;
                        state    <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (i_rx_done) begin
`ifdef LOADER_CHECKSUM_EN
                     checksum <= checksum ^ i_rx_data;
`endif
                     if (asm_complete) begin
                        o_inst_write_enable <= 1'b1;
                        o_write_addr        <= word_cnt[ADDR_WIDTH-1:0];
                        o_write_data        <= asm_word;
                        word_cnt            <= word_cnt + CNT_W'(1);
                        if (int'(word_cnt) + 1 == int'(n_words)) begin
`ifdef LOADER_CHECKSUM_EN
                           state     <= S_CHECK;
`else
                           state     <= S_DONE;
                           o_done    <= 1'b1;
                           o_loading <= 1'b0;
`endif
                        end
                     end
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               S_CHECK: begin
                  if (i_rx_done) begin
                     o_loading <= 1'b0;
                     if (i_rx_data == checksum) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                     end else begin
                        state   <= S_ERROR;
                        o_error <= 1'b1;
                     end
                  end
               end
`endif
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader; writes are checked against an expected queue.
// Checksum scenarios are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_instruction_loader;
   import loader_pkg::*;

   localparam int SIZE     = 32;
   localparam int MEM_SIZE = 64;
   localparam int AW       = 6;
   localparam int TIMEOUT  = 40;

   logic            i_clk = 1'b0;
   logic            i_rst_n = 1'b0;
   logic            i_start = 1'b0;
   logic [7:0]      i_rx_data = 8'h00;
   logic            i_rx_done = 1'b0;
   logic            o_inst_write_enable;
   logic [AW-1:0]   o_write_addr;
   logic [SIZE-1:0] o_write_data;
   logic            o_loading;
   logic            o_done;
   logic            o_error;
   state_t          o_state;

   int checks = 0;
   int errors = 0;
   int write_count = 0;
   logic [AW+SIZE-1:0] exp_q[$];
   logic [AW+SIZE-1:0] mon_exp;
   logic [SIZE-1:0]    tx_words[$];
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]         cksum_flip = 8'h00;
`endif

   instruction_loader #(
      .SIZE(SIZE), .MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .i_clk               (i_clk),
      .i_rst_n             (i_rst_n),
      .i_start             (i_start),
      .i_rx_data           (i_rx_data),
      .i_rx_done           (i_rx_done),
      .o_inst_write_enable (o_inst_write_enable),
      .o_write_addr        (o_write_addr),
      .o_write_data        (o_write_data),
      .o_loading           (o_loading),
      .o_done              (o_done),
      .o_error             (o_error),
      .o_state             (o_state)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Scoreboard: every write strobe must match the head of the expected queue.
   always @(negedge i_clk) begin
      if (o_inst_write_enable === 1'b1) begin
         write_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got addr %0d data %h, expected no write", o_write_addr, o_write_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({o_write_addr, o_write_data} !== mon_exp) begin
               errors++;
               $display("FAIL write_data: got addr %0d data %h, expected addr %0d data %h",
                        o_write_addr, o_write_data, mon_exp[AW+SIZE-1:SIZE], mon_exp[SIZE-1:0]);
            end
         end
      end
   end

   task automatic pulse_start();
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      i_rx_data = b;
      i_rx_done = 1'b1;
      @(negedge i_clk);
      i_rx_done = 1'b0;
      repeat (gap) @(negedge i_clk);
   endtask

   task automatic run_load(input int gap, input bit mid_start);
      logic [SIZE-1:0] w;
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] sum;
      sum = 8'h00;
`endif
      pulse_start();
      send_byte(8'(tx_words.size()), gap);
      for (int i = 0; i < tx_words.size(); i++) begin
         w = tx_words[i];
         exp_q.push_back({AW'(i), w});
         for (int b = 3; b >= 0; b--) begin
            send_byte(w[8*b +: 8], gap);
`ifdef LOADER_CHECKSUM_EN
            sum = sum ^ w[8*b +: 8];
`endif
         end
         if (mid_start && i == 0) begin
            pulse_start();
            checks++;
            if (o_loading !== 1'b1 || o_state !== S_DATA) begin
               errors++;
               $display("FAIL start_ignored: got loading %b state %0d, expected loading 1 state %0d",
                        o_loading, o_state, S_DATA);
            end
         end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(sum ^ cksum_flip, gap);
`endif
   endtask

   task automatic wait_end(input string name, input logic exp_done);
      int cyc;
      cyc = 0;
      while (o_done !== 1'b1 && o_error !== 1'b1 && cyc < 400) begin
         @(negedge i_clk);
         cyc++;
      end
      checks++;
      if (cyc >= 400) begin
         errors++;
         $display("FAIL %s_end: no done/error after %0d cycles, expected one", name, cyc);
      end
      checks++;
      if ({o_done, o_error, o_loading} !== {exp_done, ~exp_done, 1'b0}) begin
         errors++;
         $display("FAIL %s_flags: got done %b error %b loading %b, expected done %b error %b loading 0",
                  name, o_done, o_error, o_loading, exp_done, ~exp_done);
      end
      @(negedge i_clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_writes: got %0d expected writes missing, expected 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      i_start = 1'b1;
      i_rx_done = 1'b1;
      i_rx_data = 8'h02;
      repeat (3) @(negedge i_clk);
      checks++;
      if ({o_inst_write_enable, o_write_addr, o_write_data, o_loading, o_done, o_error} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got we %b addr %0d data %h loading %b done %b error %b, expected all 0",
                  o_inst_write_enable, o_write_addr, o_write_data, o_loading, o_done, o_error);
      end
      checks++;
      if (o_state !== S_IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d, expected %0d", o_state, S_IDLE);
      end
      i_start = 1'b0;
      i_rx_done = 1'b0;
      i_rst_n = 1'b1;
      @(negedge i_clk);
   endtask

   task automatic test_basic();
      tx_words.delete();
      tx_words.push_back(32'h12345678);
      tx_words.push_back(32'hAABBCCDD);
      run_load(1, 1'b0);
      wait_end("basic", 1'b1);
   endtask

   task automatic test_bad_count();
      logic [7:0] counts[2];
      int wc;
      counts[0] = 8'h00;
      counts[1] = 8'h41;
      for (int k = 0; k < 2; k++) begin
         wc = write_count;
         pulse_start();
         send_byte(counts[k], 0);
         wait_end("bad_count", 1'b0);
         checks++;
         if (write_count != wc) begin
            errors++;
            $display("FAIL bad_count_nowrite: got %0d writes for N=%h, expected 0", write_count - wc, counts[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      tx_words.delete();
      for (int i = 0; i < MEM_SIZE; i++) tx_words.push_back($urandom);
      run_load(0, 1'b0);
      wait_end("full_load", 1'b1);
   endtask

   task automatic test_start_during_data();
      tx_words.delete();
      for (int i = 0; i < 3; i++) tx_words.push_back($urandom);
      run_load($urandom_range(0, 2), 1'b1);
      wait_end("start_during_data", 1'b1);
   endtask

   task automatic test_timeout();
      int wc;
      wc = write_count;
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      repeat (TIMEOUT / 2) @(negedge i_clk);
      checks++;
      if (o_error !== 1'b0 || o_loading !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: got error %b loading %b, expected error 0 loading 1", o_error, o_loading);
      end
      wait_end("timeout", 1'b0);
      checks++;
      if (write_count != wc) begin
         errors++;
         $display("FAIL timeout_nowrite: got %0d writes, expected 0", write_count - wc);
      end
   endtask

   task automatic test_reset_mid_data();
      logic [SIZE-1:0] w;
      int wc;
      w = $urandom;
      pulse_start();
      send_byte(8'h02, 0);
      exp_q.push_back({AW'(0), w});
      for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], 0);
      send_byte(8'h5A, 0);
      send_byte(8'hA5, 0);
      wc = write_count;
      i_rst_n = 1'b0;
      @(negedge i_clk);
      checks++;
      if ({o_inst_write_enable, o_write_addr, o_write_data, o_loading, o_done, o_error} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got we %b addr %0d data %h loading %b done %b error %b, expected all 0",
                  o_inst_write_enable, o_write_addr, o_write_data, o_loading, o_done, o_error);
      end
      i_rst_n = 1'b1;
      repeat (3) @(negedge i_clk);
      checks++;
      if (write_count != wc || exp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_mid_writes: got %0d extra writes and %0d pending, expected 0 and 0",
                  write_count - wc, exp_q.size());
      end
      exp_q.delete();
      tx_words.delete();
      tx_words.push_back($urandom);
      tx_words.push_back($urandom);
      run_load(0, 1'b0);
      wait_end("reload_after_reset", 1'b1);
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      tx_words.delete();
      tx_words.push_back(32'h11223344);
      cksum_flip = 8'h00;
      run_load(1, 1'b0);
      wait_end("checksum_good", 1'b1);
      cksum_flip = 8'h01;
      run_load(1, 1'b0);
      wait_end("checksum_bad", 1'b0);
      cksum_flip = 8'h00;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_bad_count();
      test_back_to_back();
      test_start_during_data();
      test_timeout();
      test_reset_mid_data();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      repeat (2) @(negedge i_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
